// File: rtl/line_buffer_stream_pkg.sv
// Shared constants and width helpers for the streaming line buffer.
// Types whose widths depend on instance parameters cannot live in the
// package. The width functions below stand in for them, so every file
// sizes its buses the same way.
package line_buffer_pkg;

   localparam int unsigned DEF_NUM_LINES  = 3;
   localparam int unsigned DEF_DATA_WIDTH = 16;
   localparam int unsigned DEF_NUM_CH     = 1;
   localparam int unsigned DEF_MAX_COLS   = 1024;

   // Width of one multi-channel pixel.
   function automatic int unsigned pixel_w(int unsigned data_width, int unsigned num_ch);
      return data_width * num_ch;
   endfunction

   // Width of the full output column (all lanes).
   function automatic int unsigned lane_w(int unsigned num_lines, int unsigned data_width,
                                          int unsigned num_ch);
      return num_lines * pixel_w(data_width, num_ch);
   endfunction

   // Column counter width.
   function automatic int unsigned col_w(int unsigned max_cols);
      return (max_cols > 1) ? $clog2(max_cols) : 1;
   endfunction

   // Ring pointer width over the K-1 line memories.
   function automatic int unsigned wp_w(int unsigned num_lines);
      return (num_lines > 2) ? $clog2(num_lines - 1) : 1;
   endfunction

   // Row counter width; the counter saturates at K-1.
   function automatic int unsigned rows_w(int unsigned num_lines);
      return $clog2(num_lines);
   endfunction

   // Memory feeding output lane `lane` (1..K-1) when `wp` holds the oldest row.
   function automatic int unsigned lane_mem(int unsigned wp, int unsigned lane,
                                            int unsigned num_lines);
      return (wp + num_lines - 1 - lane) % (num_lines - 1);
   endfunction

endpackage

// File: rtl/line_buffer_stream_if.sv
// Pixel-in / column-out stream bundle for line_buffer_stream.
//   s_*    : upstream pixel stream (valid/ready, data, sof, eol)
//   m_*    : downstream column stream (valid/ready, data, col, eol)
// The slave modport is the line buffer. The master modport is its
// environment, which drives the input pixels and the downstream ready.
interface line_buffer_stream_if #(
   parameter int unsigned NUM_LINES  = line_buffer_pkg::DEF_NUM_LINES,
   parameter int unsigned DATA_WIDTH = line_buffer_pkg::DEF_DATA_WIDTH,
   parameter int unsigned NUM_CH     = line_buffer_pkg::DEF_NUM_CH,
   parameter int unsigned MAX_COLS   = line_buffer_pkg::DEF_MAX_COLS
);
   import line_buffer_pkg::*;

   localparam int unsigned PIX_W  = pixel_w(DATA_WIDTH, NUM_CH);
   localparam int unsigned LANE_W = lane_w(NUM_LINES, DATA_WIDTH, NUM_CH);
   localparam int unsigned COL_W  = col_w(MAX_COLS);

   logic              s_valid;
   logic              s_ready;
   logic [PIX_W-1:0]  s_data;
   logic              s_sof;
   logic              s_eol;
   logic              m_valid;
   logic              m_ready;
   logic [LANE_W-1:0] m_data;
   logic [COL_W-1:0]  m_col;
   logic              m_eol;

   modport master (
      output s_valid, s_data, s_sof, s_eol, m_ready,
      input  s_ready, m_valid, m_data, m_col, m_eol
   );

   modport slave (
      input  s_valid, s_data, s_sof, s_eol, m_ready,
      output s_ready, m_valid, m_data, m_col, m_eol
   );

endinterface

// File: rtl/line_buffer_stream_lb_line_ram.sv
// Single-port read-first synchronous RAM holding one image line.
//   clk   : clock
//   en    : port enable; rdata holds its value while low
//   we    : write enable (qualified by en)
//   addr  : column address
//   wdata : pixel written at addr
//   rdata : previous contents of addr, registered
module lb_line_ram #(
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  wdata,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Read-first: rdata returns the old row, and the same access stores the new one.
   always_ff @(posedge clk) begin
      if (en) begin
         rdata <= mem[addr];
         if (we) begin
            mem[addr] <= wdata;
         end
      end
   end

endmodule

// File: rtl/line_buffer_stream.sv
// Streaming line buffer. Takes one pixel per clock in raster order and
// emits a vertical column of NUM_LINES pixels (current row first) for
// each accepted pixel, with a latency of one cycle.
//   clk    : clock
//   reset  : asynchronous active-low reset
//   pad_en : 1 = emit from row 0 and zero the missing upper lanes
//   ovf    : sticky flag, set when a line reaches MAX_COLS without eol
//   bus    : pixel-in / column-out stream (slave side)
module line_buffer_stream
   import line_buffer_pkg::*;
#(
   parameter int unsigned NUM_LINES  = DEF_NUM_LINES,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned NUM_CH     = DEF_NUM_CH,
   parameter int unsigned MAX_COLS   = DEF_MAX_COLS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pad_en,
   output logic                 ovf,
   line_buffer_stream_if.slave  bus
);

   localparam int unsigned PIX_W     = pixel_w(DATA_WIDTH, NUM_CH);
   localparam int unsigned LANE_W    = lane_w(NUM_LINES, DATA_WIDTH, NUM_CH);
   localparam int unsigned COL_W     = col_w(MAX_COLS);
   localparam int unsigned WP_W      = wp_w(NUM_LINES);
   localparam int unsigned ROWS_W    = rows_w(NUM_LINES);
   localparam int unsigned NUM_MEMS  = NUM_LINES - 1;
   localparam int unsigned LAST_COL  = MAX_COLS - 1;
   localparam int unsigned LAST_WP   = NUM_MEMS - 1;
   localparam int unsigned FULL_ROWS = NUM_LINES - 1;

   logic                  accept;
   logic [COL_W-1:0]      col_q, col_cur, col_nxt;
   logic [ROWS_W-1:0]     rows_q, rows_cur, rows_nxt;
   logic [WP_W-1:0]       wp_q, wp_cur, wp_nxt;
   logic                  eol_eff, forced_eol, produce;
   logic [NUM_LINES-1:1]  keep_cur;

   logic                  m_valid_q, m_eol_q, ovf_q;
   logic [COL_W-1:0]      m_col_q;
   logic [PIX_W-1:0]      lane0_q;
   logic [WP_W-1:0]       out_wp_q;
   logic [NUM_LINES-1:1]  keep_q;
   logic [PIX_W-1:0]      ram_q [NUM_MEMS];
   logic [LANE_W-1:0]     m_data_c;

   assign accept      = bus.s_valid && (!m_valid_q || bus.m_ready);
   assign bus.s_ready = !m_valid_q || bus.m_ready;

   // Position of the pixel being offered. An sof pixel overrides stale counters.
   always_comb begin
      col_cur    = bus.s_sof ? '0 : col_q;
      rows_cur   = bus.s_sof ? '0 : rows_q;
      wp_cur     = bus.s_sof ? '0 : wp_q;
      forced_eol = (col_cur == COL_W'(LAST_COL)) && !bus.s_eol;
      eol_eff    = bus.s_eol || forced_eol;
      col_nxt    = eol_eff ? '0 : col_cur + COL_W'(1);
      rows_nxt   = rows_cur;
      wp_nxt     = wp_cur;
      if (eol_eff) begin
         if (rows_cur != ROWS_W'(FULL_ROWS)) begin
            rows_nxt = rows_cur + ROWS_W'(1);
         end
         wp_nxt = (wp_cur == WP_W'(LAST_WP)) ? '0 : wp_cur + WP_W'(1);
      end
      produce  = pad_en || (rows_cur == ROWS_W'(FULL_ROWS));
      keep_cur = '0;
      for (int i = 1; i < NUM_LINES; i++) begin
         keep_cur[i] = (ROWS_W'(i) <= rows_cur);
      end
   end

   // Line memories. All are read on each accept. The one holding the oldest row is also overwritten.
   for (genvar m = 0; m < NUM_MEMS; m++) begin : g_line
      lb_line_ram #(
         .DEPTH  (MAX_COLS),
         .WIDTH  (PIX_W),
         .ADDR_W (COL_W)
      ) u_ram (
         .clk   (clk),
         .en    (accept),
         .we    (accept && (wp_cur == WP_W'(m))),
         .addr  (col_cur),
         .wdata (bus.s_data),
         .rdata (ram_q[m])
      );
   end

   // Counters and output register. All of them advance only on accept.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_q     <= '0;
         rows_q    <= '0;
         wp_q      <= '0;
         m_valid_q <= 1'b0;
         m_col_q   <= '0;
         m_eol_q   <= 1'b0;
         lane0_q   <= '0;
         out_wp_q  <= '0;
         keep_q    <= '0;
         ovf_q     <= 1'b0;
      end else if (accept) begin
         col_q     <= col_nxt;
         rows_q    <= rows_nxt;
         wp_q      <= wp_nxt;
         m_valid_q <= produce;
         m_col_q   <= col_cur;
         m_eol_q   <= eol_eff;
         lane0_q   <= bus.s_data;
         out_wp_q  <= wp_cur;
         keep_q    <= keep_cur;
         ovf_q     <= forced_eol || (ovf_q && !bus.s_sof);
      end else if (bus.m_ready) begin
         m_valid_q <= 1'b0;
      end
   end

   // Put the RAM outputs in age order and zero the lanes that have no row yet.
   always_comb begin
      m_data_c            = '0;
      m_data_c[PIX_W-1:0] = lane0_q;
      for (int i = 1; i < NUM_LINES; i++) begin
         if (keep_q[i]) begin
            m_data_c[i*PIX_W +: PIX_W] =
               ram_q[WP_W'(lane_mem(32'(out_wp_q), i, NUM_LINES))];
         end
      end
   end

   assign bus.m_valid = m_valid_q;
   assign bus.m_data  = m_data_c;
   assign bus.m_col   = m_col_q;
   assign bus.m_eol   = m_eol_q;
   assign ovf         = ovf_q;

endmodule

// File: tb/tb_line_buffer_stream.sv
// Directed testbench for line_buffer_stream (K=3, 16-bit, 1 channel, 16 columns).
module tb_line_buffer_stream;

   localparam int unsigned K    = 3;
   localparam int unsigned DW   = 16;
   localparam int unsigned NCH  = 1;
   localparam int unsigned MAXC = 16;

   logic clk = 1'b0;
   logic reset;
   logic pad_en;
   logic ovf;
   int   vectors     = 0;
   int   miscompares = 0;

   line_buffer_stream_if #(.NUM_LINES(K), .DATA_WIDTH(DW), .NUM_CH(NCH), .MAX_COLS(MAXC)) bus ();

   line_buffer_stream #(.NUM_LINES(K), .DATA_WIDTH(DW), .NUM_CH(NCH), .MAX_COLS(MAXC)) dut (
      .clk    (clk),
      .reset  (reset),
      .pad_en (pad_en),
      .ovf    (ovf),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] d;
      logic        sof;
      logic        eol;
   } px_t;

   typedef struct packed {
      logic [47:0] d;
      logic [3:0]  col;
      logic        eol;
   } exp_t;

   px_t  px_q[$];
   exp_t exp_q[$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] d, input logic sof, input logic eol);
      bus.s_valid = v;
      bus.s_data  = d;
      bus.s_sof   = sof;
      bus.s_eol   = eol;
   endtask

   // Frame with pixel value base+row. Columns come out only from row 2 on (no padding).
   function automatic void add_frame(input int rows, input int cols, input int base);
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < cols; c++) begin
            px_q.push_back('{d: 16'(base + r), sof: (r == 0 && c == 0), eol: (c == cols - 1)});
            if (r >= 2) begin
               exp_q.push_back('{d: {16'(base + r - 2), 16'(base + r - 1), 16'(base + r)},
                                 col: 4'(c), eol: (c == cols - 1)});
            end
         end
      end
   endfunction

   // Streams px_q and checks every presented column against exp_q in order.
   task automatic run_stream(input string name, input bit rand_ready, input int stall_idx);
      int idx       = 0;
      int out_idx   = 0;
      int stall_cnt = 0;
      int cycles    = 0;
      bit done      = 1'b0;
      while (!done && cycles < 4000) begin
         bus.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_idx == stall_idx && stall_cnt < 5 && bus.m_valid) bus.m_ready = 1'b0;
         if (idx < px_q.size()) drive(1'b1, px_q[idx].d, px_q[idx].sof, px_q[idx].eol);
         else                   drive(1'b0, 16'h0, 1'b0, 1'b0);
         #1;
         if (bus.m_valid) begin
            vectors++;
            if (out_idx >= exp_q.size()) begin
               miscompares++;
               $display("FAIL %s_extra: got column col=%0d data=%h, want none (all %0d done)",
                        name, bus.m_col, bus.m_data, exp_q.size());
            end else if (bus.m_data !== exp_q[out_idx].d || bus.m_col !== exp_q[out_idx].col ||
                         bus.m_eol !== exp_q[out_idx].eol) begin
               miscompares++;
               $display("FAIL %s_out%0d: got data=%h col=%0d eol=%b want data=%h col=%0d eol=%b",
                        name, out_idx, bus.m_data, bus.m_col, bus.m_eol,
                        exp_q[out_idx].d, exp_q[out_idx].col, exp_q[out_idx].eol);
            end
            if (!bus.m_ready && out_idx == stall_idx) begin
               stall_cnt++;
               vectors++;
               if (bus.s_ready !== 1'b0) begin
                  miscompares++;
                  $display("FAIL %s_stall_s_ready: got %b want 0", name, bus.s_ready);
               end
            end
            if (bus.m_ready) out_idx++;
         end
         if (bus.s_valid && bus.s_ready) idx++;
         done = (idx == px_q.size()) && (out_idx == exp_q.size());
         step();
         cycles++;
      end
      drive(1'b0, 16'h0, 1'b0, 1'b0);
      bus.m_ready = 1'b1;
      vectors++;
      if (!done) begin
         miscompares++;
         $display("FAIL %s_timeout: got %0d/%0d in, %0d/%0d out", name, idx, px_q.size(),
                  out_idx, exp_q.size());
      end
      vectors++;
      if (bus.m_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_trailing_valid: got %b want 0", name, bus.m_valid);
      end
      px_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      reset       = 1'b0;
      pad_en      = 1'b0;
      bus.m_ready = 1'b1;
      drive(1'b0, 16'h0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1 || ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got m_valid=%b s_ready=%b ovf=%b want 0 1 0",
                  bus.m_valid, bus.s_ready, ovf);
      end
      vectors++;
      if (bus.m_data !== 48'h0 || bus.m_col !== 4'h0 || bus.m_eol !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_data: got data=%h col=%0d eol=%b want 0 0 0",
                  bus.m_data, bus.m_col, bus.m_eol);
      end
      reset = 1'b1;
      step();
   endtask

   task automatic test_priming();
      logic [47:0] exp_d;
      pad_en      = 1'b0;
      bus.m_ready = 1'b1;
      for (int r = 0; r < 6; r++) begin
         for (int c = 0; c < 8; c++) begin
            drive(1'b1, 16'(r), (r == 0 && c == 0), (c == 7));
            step();
            vectors++;
            if (bus.m_valid !== (r >= 2)) begin
               miscompares++;
               $display("FAIL prime_valid r%0d c%0d: got %b want %b", r, c, bus.m_valid, (r >= 2));
            end
            if (r >= 2) begin
               exp_d = {16'(r - 2), 16'(r - 1), 16'(r)};
               vectors++;
               if (bus.m_data !== exp_d || bus.m_col !== 4'(c) || bus.m_eol !== (c == 7)) begin
                  miscompares++;
                  $display("FAIL prime_col r%0d c%0d: got data=%h col=%0d eol=%b want data=%h col=%0d eol=%b",
                           r, c, bus.m_data, bus.m_col, bus.m_eol, exp_d, c, (c == 7));
               end
            end
         end
      end
      drive(1'b0, 16'h0, 1'b0, 1'b0);
      step();
      vectors++;
      if (bus.m_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL prime_drain: got m_valid=%b want 0", bus.m_valid);
      end
   endtask

   task automatic test_padding();
      logic [47:0] exp_d;
      pad_en      = 1'b1;
      bus.m_ready = 1'b1;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 4; c++) begin
            drive(1'b1, 16'(r + 1), (r == 0 && c == 0), (c == 3));
            step();
            exp_d = {(r >= 2) ? 16'(r - 1) : 16'h0, (r >= 1) ? 16'(r) : 16'h0, 16'(r + 1)};
            vectors++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== exp_d || bus.m_col !== 4'(c)) begin
               miscompares++;
               $display("FAIL pad r%0d c%0d: got valid=%b data=%h col=%0d want 1 %h %0d",
                        r, c, bus.m_valid, bus.m_data, bus.m_col, exp_d, c);
            end
         end
      end
      drive(1'b0, 16'h0, 1'b0, 1'b0);
      step();
      pad_en = 1'b0;
   endtask

   task automatic test_backpressure();
      pad_en = 1'b0;
      add_frame(4, 8, 0);
      run_stream("backpressure", 1'b0, 12);
   endtask

   task automatic test_frame_restart();
      pad_en = 1'b0;
      add_frame(4, 8, 0);
      add_frame(4, 8, 100);
      run_stream("restart", 1'b0, -1);
   endtask

   task automatic test_random_ready();
      pad_en = 1'b0;
      add_frame(20, 8, 200);
      run_stream("random_ready", 1'b1, -1);
   endtask

   task automatic test_overflow();
      pad_en      = 1'b1;
      bus.m_ready = 1'b1;
      for (int k = 0; k < 17; k++) begin
         drive(1'b1, 16'h0100 + 16'(k), (k == 0), 1'b0);
         step();
         vectors++;
         if (bus.m_col !== 4'((k <= 15) ? k : 0) || bus.m_eol !== (k == 15) || ovf !== (k >= 15)) begin
            miscompares++;
            $display("FAIL ovf_px%0d: got col=%0d eol=%b ovf=%b want col=%0d eol=%b ovf=%b",
                     k, bus.m_col, bus.m_eol, ovf, (k <= 15) ? k : 0, (k == 15), (k >= 15));
         end
      end
      vectors++;
      if (bus.m_data !== {16'h0000, 16'h0100, 16'h0110}) begin
         miscompares++;
         $display("FAIL ovf_wrap_data: got %h want %h", bus.m_data, {16'h0000, 16'h0100, 16'h0110});
      end
      drive(1'b1, 16'h0200, 1'b1, 1'b1);
      step();
      vectors++;
      if (ovf !== 1'b0 || bus.m_eol !== 1'b1 || bus.m_col !== 4'h0 ||
          bus.m_data !== {16'h0000, 16'h0000, 16'h0200}) begin
         miscompares++;
         $display("FAIL sof_eol_px: got ovf=%b eol=%b col=%0d data=%h want 0 1 0 %h",
                  ovf, bus.m_eol, bus.m_col, bus.m_data, {16'h0000, 16'h0000, 16'h0200});
      end
      drive(1'b1, 16'h0201, 1'b0, 1'b1);
      step();
      vectors++;
      if (bus.m_col !== 4'h0 || bus.m_eol !== 1'b1 || bus.m_data !== {16'h0000, 16'h0200, 16'h0201}) begin
         miscompares++;
         $display("FAIL single_px_line_next: got col=%0d eol=%b data=%h want 0 1 %h",
                  bus.m_col, bus.m_eol, bus.m_data, {16'h0000, 16'h0200, 16'h0201});
      end
      drive(1'b0, 16'h0, 1'b0, 1'b0);
      step();
      pad_en = 1'b0;
   endtask

   task automatic test_reset_midstream();
      pad_en      = 1'b1;
      bus.m_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         drive(1'b1, 16'h0300 + 16'(k), (k == 0), 1'b0);
         step();
      end
      bus.m_ready = 1'b0;
      drive(1'b0, 16'h0, 1'b0, 1'b0);
      step();
      vectors++;
      if (ovf !== 1'b1 || bus.m_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL midreset_pre: got ovf=%b m_valid=%b want 1 1", ovf, bus.m_valid);
      end
      #2 reset = 1'b0;
      #1;
      vectors++;
      if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1 || ovf !== 1'b0 || bus.m_data !== 48'h0) begin
         miscompares++;
         $display("FAIL midreset: got m_valid=%b s_ready=%b ovf=%b data=%h want 0 1 0 0",
                  bus.m_valid, bus.s_ready, ovf, bus.m_data);
      end
      @(posedge clk);
      #1;
      reset       = 1'b1;
      pad_en      = 1'b0;
      bus.m_ready = 1'b1;
      add_frame(3, 4, 50);
      run_stream("post_reset", 1'b0, -1);
   endtask

   initial begin
      test_reset();
      test_priming();
      test_padding();
      test_backpressure();
      test_frame_restart();
      test_random_ready();
      test_overflow();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
